// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: default word width and the slot-count to keep-mask helper.
package axis_pkg;

  localparam int unsigned AXIS_WORD_W    = 8;
  localparam int unsigned AXIS_MAX_RATIO = 16;

  // Bit i set for every slot i < nslots; callers size-cast down to their own RATIO.
  function automatic logic [AXIS_MAX_RATIO-1:0] keep_mask(input int unsigned nslots);
    logic [AXIS_MAX_RATIO-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < AXIS_MAX_RATIO; i++) begin
      if (i < nslots) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO input beats (first beat in the LSB slot) into one output beat.
// Optional TLAST/TKEEP support is enabled by defining AXIS_UPSIZER_LAST_EN.
module axis_upsizer
  import axis_pkg::*;
#(
  parameter int unsigned WORD_W  = AXIS_WORD_W,
  parameter int unsigned S_WORDS = 1,
  parameter int unsigned RATIO   = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [S_WORDS*WORD_W-1:0]       s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [RATIO*S_WORDS*WORD_W-1:0] m_data
`ifdef AXIS_UPSIZER_LAST_EN
  ,
  input  logic                            s_last,
  output logic                            m_last,
  output logic [RATIO-1:0]                m_keep
`endif
);

  localparam int unsigned S_W   = S_WORDS * WORD_W;
  localparam int unsigned CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [RATIO-1:0][S_W-1:0] acc_q, acc_d;
  logic [RATIO-1:0][S_W-1:0] m_data_q, m_data_d;
  logic [RATIO-1:0][S_W-1:0] pack;
  logic                      m_valid_q, m_valid_d;
  logic                      accept;
  logic                      last_beat;
  logic                      load;
`ifdef AXIS_UPSIZER_LAST_EN
  logic                      m_last_q, m_last_d;
  logic [RATIO-1:0]          m_keep_q, m_keep_d;
`endif

  always_comb begin
`ifdef AXIS_UPSIZER_LAST_EN
    // Any slot may complete a beat, so the output register must be free before accepting.
    s_ready   = ~m_valid_q | m_ready;
    last_beat = s_last;
`else
    s_ready   = (cnt_q != CNT_LAST) | ~m_valid_q | m_ready;
    last_beat = 1'b0;
`endif
    accept = s_valid & s_ready;
    load   = accept & ((cnt_q == CNT_LAST) | last_beat);

    // Slots below cnt come from acc, slot cnt is the incoming beat, anything above stays zero.
    pack = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (i < 32'(cnt_q)) begin
        pack[i] = acc_q[i];
      end else if (i == 32'(cnt_q)) begin
        pack[i] = s_data;
      end
    end

    acc_d = acc_q;
    if (accept) acc_d[cnt_q] = s_data;

    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = pack;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end

`ifdef AXIS_UPSIZER_LAST_EN
    m_last_d = m_last_q;
    m_keep_d = m_keep_q;
    if (load) begin
      m_last_d = s_last;
      m_keep_d = RATIO'(keep_mask(32'(cnt_q) + 32'd1));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
`ifdef AXIS_UPSIZER_LAST_EN
      m_last_q  <= 1'b0;
      m_keep_q  <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
`ifdef AXIS_UPSIZER_LAST_EN
      m_last_q  <= m_last_d;
      m_keep_q  <= m_keep_d;
`endif
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
`ifdef AXIS_UPSIZER_LAST_EN
  assign m_last  = m_last_q;
  assign m_keep  = m_keep_q;
`endif

endmodule

// File: tb/tb_axis_upsizer.sv
// Self-checking bench for axis_upsizer (WORD_W=8, S_WORDS=1, RATIO=4) against a transaction-queue model.
module tb_axis_upsizer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
`ifdef AXIS_UPSIZER_LAST_EN
  logic        s_last;
  logic        m_last;
  logic [3:0]  m_keep;
`endif

  axis_upsizer #(.WORD_W(8), .S_WORDS(1), .RATIO(4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef AXIS_UPSIZER_LAST_EN
    ,
    .s_last  (s_last),
    .m_last  (m_last),
    .m_keep  (m_keep)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } out_t;

  // Model: completed output words waiting to be consumed, plus the beats of the word being built.
  out_t        pend[$];
  logic [7:0]  part[4];
  int unsigned nacc;

  int checks;
  int errors;

  logic        obs_sready, obs_mvalid, obs_mlast;
  logic [31:0] obs_mdata;
  logic [3:0]  obs_mkeep;
  logic        exp_sready, exp_mvalid, exp_mlast;
  logic [31:0] exp_mdata;
  logic [3:0]  exp_mkeep;
  logic        took;

  task automatic model_clear();
    pend.delete();
    nacc = 0;
  endtask

  // Drive one cycle at the negedge, sample #1 later, then advance the model by the expected handshakes.
  task automatic step(input logic sv, input logic [7:0] sd, input logic sl, input logic mr);
    out_t o;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
`ifdef AXIS_UPSIZER_LAST_EN
    s_last  = sl;
`endif
    #1;
    obs_sready = s_ready;
    obs_mvalid = m_valid;
    obs_mdata  = m_data;
`ifdef AXIS_UPSIZER_LAST_EN
    obs_mlast  = m_last;
    obs_mkeep  = m_keep;
`else
    obs_mlast  = 1'b0;
    obs_mkeep  = 4'hF;
`endif
    exp_mvalid = (pend.size() > 0);
    exp_mdata  = exp_mvalid ? pend[0].data : 32'h0;
    exp_mkeep  = exp_mvalid ? pend[0].keep : 4'h0;
    exp_mlast  = exp_mvalid ? pend[0].last : 1'b0;
`ifdef AXIS_UPSIZER_LAST_EN
    exp_sready = !(exp_mvalid && !mr);
`else
    exp_sready = !(nacc == 3 && exp_mvalid && !mr);
`endif
    took = sv && exp_sready;
    if (exp_mvalid && mr) void'(pend.pop_front());
    if (took) begin
      part[nacc] = sd;
      nacc++;
      if (nacc == 4 || sl) begin
        o.data = 32'h0;
        for (int k = 0; k < int'(nacc); k++) o.data[8*k +: 8] = part[k];
        o.keep = 4'((1 << nacc) - 1);
        o.last = sl;
        pend.push_back(o);
        nacc = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
`ifdef AXIS_UPSIZER_LAST_EN
    s_last  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_sready_during got %b want 1", s_ready);
    end
    rstn = 1'b1;
    @(negedge clk);
    model_clear();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mvalid got %b want 0", m_valid);
    end
    checks++;
    if (m_data !== 32'h0) begin
      errors++; $display("FAIL reset_mdata got %h want 00000000", m_data);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_sready_after got %b want 1", s_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = 8'h11 * 8'(k + 1);
      step(1'b1, b, 1'b0, 1'b1);
      checks++;
      if (obs_sready !== 1'b1 || obs_mvalid !== 1'b0) begin
        errors++; $display("FAIL basic_fill beat %0d got sready=%b mvalid=%b want 1 0", k, obs_sready, obs_mvalid);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (obs_mvalid !== 1'b1) begin
      errors++; $display("FAIL basic_latency got mvalid=%b want 1", obs_mvalid);
    end
    checks++;
    if (obs_mdata !== 32'h44332211) begin
      errors++; $display("FAIL basic_data got %h want 44332211", obs_mdata);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (obs_mvalid !== 1'b0) begin
      errors++; $display("FAIL basic_single_cycle got mvalid=%b want 0", obs_mvalid);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d[8];
    int idx;
    for (int k = 0; k < 8; k++) d[k] = 8'hB0 + 8'(k);
    for (int k = 0; k < 4; k++) step(1'b1, d[k], 1'b0, 1'b0);
    idx = 4;
    for (int c = 0; c < 10; c++) begin
      step(idx < 7, d[idx], 1'b0, 1'b0);
      if (took) idx++;
      checks++;
      if (obs_sready !== exp_sready) begin
        errors++; $display("FAIL bp_sready cycle %0d got %b want %b", c, obs_sready, exp_sready);
      end
      checks++;
      if (obs_mvalid !== 1'b1 || obs_mdata !== 32'hB3B2B1B0) begin
        errors++; $display("FAIL bp_hold cycle %0d got %b/%h want 1/b3b2b1b0", c, obs_mvalid, obs_mdata);
      end
    end
    checks++;
    if (idx !== 7 || obs_sready !== 1'b0) begin
      errors++; $display("FAIL bp_stall got beats=%0d sready=%b want 7 0", idx, obs_sready);
    end
    step(1'b1, d[7], 1'b0, 1'b1);
    checks++;
    if (obs_sready !== 1'b1 || obs_mdata !== 32'hB3B2B1B0) begin
      errors++; $display("FAIL bp_release got sready=%b data=%h want 1 b3b2b1b0", obs_sready, obs_mdata);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (obs_mvalid !== 1'b1 || obs_mdata !== 32'hB7B6B5B4) begin
      errors++; $display("FAIL bp_second got %b/%h want 1/b7b6b5b4", obs_mvalid, obs_mdata);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (obs_mvalid !== 1'b0) begin
      errors++; $display("FAIL bp_drain got mvalid=%b want 0", obs_mvalid);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b1, 8'h66, 1'b0, 1'b1);
    rstn    = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
    for (int k = 0; k < 4; k++) step(1'b1, 8'hA1 + 8'(k), 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (obs_mvalid !== 1'b1 || obs_mdata !== 32'hA4A3A2A1) begin
      errors++; $display("FAIL reset_mid got %b/%h want 1/a4a3a2a1", obs_mvalid, obs_mdata);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] b;
    int cyc;
    int hold_err;
    logic        prev_stall;
    logic [31:0] prev_data;
    cyc = 0;
    hold_err = 0;
    prev_stall = 1'b0;
    prev_data = 32'h0;
    for (int p = 0; p < 100 && cyc < 60000; p++) begin
      for (int k = 0; k < 40 && cyc < 60000; k++) begin
        b = 8'($urandom);
        took = 1'b0;
        while (!took && cyc < 60000) begin
          step(1'b1, b, 1'b0, $urandom_range(0, 9) == 0);
          cyc++;
          checks++;
          if (obs_sready !== exp_sready) begin
            errors++; $display("FAIL rand_sready cyc %0d got %b want %b", cyc, obs_sready, exp_sready);
          end
          checks++;
          if (obs_mvalid !== exp_mvalid) begin
            errors++; $display("FAIL rand_mvalid cyc %0d got %b want %b", cyc, obs_mvalid, exp_mvalid);
          end
          if (exp_mvalid) begin
            checks++;
            if (obs_mdata !== exp_mdata) begin
              errors++; $display("FAIL rand_mdata cyc %0d got %h want %h", cyc, obs_mdata, exp_mdata);
            end
          end
          if (prev_stall) begin
            checks++;
            if (obs_mvalid !== 1'b1 || obs_mdata !== prev_data) begin
              errors++; $display("FAIL rand_hold cyc %0d got %b/%h want 1/%h", cyc, obs_mvalid, obs_mdata, prev_data);
            end
          end
          prev_stall = obs_mvalid && !m_ready;
          prev_data  = obs_mdata;
        end
      end
    end
    checks++;
    if (cyc >= 60000) begin
      errors++; $display("FAIL rand_timeout got %0d cycles want < 60000", cyc);
    end
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      if (exp_mvalid) begin
        checks++;
        if (obs_mdata !== exp_mdata) begin
          errors++; $display("FAIL rand_tail got %h want %h", obs_mdata, exp_mdata);
        end
      end
    end
    checks++;
    if (obs_mvalid !== 1'b0) begin
      errors++; $display("FAIL rand_drain got mvalid=%b want 0", obs_mvalid);
    end
  endtask

`ifdef AXIS_UPSIZER_LAST_EN
  task automatic test_last();
    step(1'b1, 8'h01, 1'b0, 1'b1);
    step(1'b1, 8'h02, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (obs_mvalid !== 1'b1 || obs_mdata !== 32'h00000201) begin
      errors++; $display("FAIL last_data got %b/%h want 1/00000201", obs_mvalid, obs_mdata);
    end
    checks++;
    if (obs_mkeep !== 4'b0011 || obs_mlast !== 1'b1) begin
      errors++; $display("FAIL last_keep got keep=%b last=%b want 0011 1", obs_mkeep, obs_mlast);
    end
    for (int k = 0; k < 4; k++) step(1'b1, 8'h03 + 8'(k), 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (obs_mdata !== 32'h06050403 || obs_mkeep !== 4'b1111 || obs_mlast !== 1'b0) begin
      errors++; $display("FAIL last_next got %h/%b/%b want 06050403/1111/0", obs_mdata, obs_mkeep, obs_mlast);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    nacc   = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
`ifdef AXIS_UPSIZER_LAST_EN
    test_last();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_upsizer.md
AXIS_UPSIZER -- requirements
Module: axis_upsizer

Interface
REQ-001 SHALL have parameter WORD_W, default 8: bits per word.
REQ-002 SHALL have parameter S_WORDS, default 1: words per input beat; S_W = S_WORDS*WORD_W.
REQ-003 SHALL have parameter RATIO, default 4, legal range 2..16: input beats per output beat; M_W = RATIO*S_W.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rstn, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port s_valid, input, 1: input beat valid.
REQ-007 SHALL have port s_ready, output, 1: input beat accepted when s_valid & s_ready.
REQ-008 SHALL have port s_data, input, S_W: input beat.
REQ-009 SHALL have port m_valid, output, 1: output beat valid.
REQ-010 SHALL have port m_ready, input, 1: downstream ready; downstream is typically skid_buffer, WIDTH=M_W.
REQ-011 SHALL have port m_data, output, M_W: packed output beat.

Function
REQ-012 SHALL keep slot counter cnt, range 0..RATIO-1, width $clog2(RATIO), and accumulator acc of RATIO slots of S_W.
REQ-013 SHALL write each accepted input beat into acc slot cnt; slot 0 occupies m_data[S_W-1:0]; the first beat received goes to the LSB slot.
REQ-014 SHALL, on acceptance with cnt<RATIO-1, increment cnt.
REQ-015 SHALL, on acceptance with cnt==RATIO-1, load {s_data, acc[RATIO-2:0]} into the output register, set m_valid, and wrap cnt to 0 on the same edge.
REQ-016 SHALL drive s_ready = (cnt!=RATIO-1) | ~m_valid | m_ready; the output is combinational from registers and m_ready only, never from s_valid.
REQ-017 SHALL hold m_valid and m_data stable while m_valid & ~m_ready (AXIS rule).
REQ-018 SHALL clear m_valid after m_valid & m_ready unless a new output loads on the same edge; in that case m_valid stays 1 with the new data.
REQ-019 SHALL have latency of exactly 1 cycle: m_valid rises on the edge following the edge that accepts the last beat.
REQ-020 SHALL sustain 1 input beat per cycle indefinitely while m_ready=1, giving 1 output per RATIO cycles.
REQ-021 SHALL leave cnt and acc unchanged in cycles without acceptance; gaps in s_valid do not disturb packing.
REQ-022 SHALL never drop or duplicate a beat under any s_valid/m_ready pattern.

Reset
REQ-023 SHALL, with rstn=0 at a rising edge, set m_valid=0, cnt=0, m_data=0, acc=0; s_ready reads 1 during and after reset.
REQ-024 SHALL discard any partially packed or pending output beat on reset mid-operation; the first beat after reset lands in slot 0.

Configuration
REQ-025 SHALL, with macro AXIS_UPSIZER_LAST_EN defined, add ports s_last (input, 1), m_last (output, 1) and m_keep (output, RATIO, one bit per slot).
REQ-026 SHALL, with AXIS_UPSIZER_LAST_EN defined, emit the output on acceptance of a beat with s_last=1 at any cnt, with m_last=1, m_keep bits [cnt:0] set, unfilled slots zero, and cnt reset to 0.
REQ-027 SHALL, with AXIS_UPSIZER_LAST_EN defined, force s_ready = ~m_valid | m_ready whenever the slot about to be filled could complete a beat; the simplest legal rule is s_ready = ~m_valid | m_ready at all cnt values.
REQ-028 SHALL, with AXIS_UPSIZER_LAST_EN defined, drive m_keep all-ones and m_last=0 on full beats without s_last.
REQ-029 SHALL, without the macro, omit those ports entirely and behave per REQ-012..022.

Structure
REQ-030 SHALL take default WORD_W and a keep-mask helper function (slot count -> RATIO-bit mask) from shared package axis_pkg.
REQ-031 SHALL need no sub-module; a single always_ff for cnt/acc/output plus combinational s_ready.

Verification
REQ-032 SHALL cover: RATIO=4, beats 0x11,0x22,0x33,0x44 back-to-back, m_ready=1 -> m_data=0x44332211, m_valid high exactly one cycle after 0x44 is accepted.
REQ-033 SHALL cover: m_ready=0 for 10 cycles with a full beat pending plus 3 more beats sent -> s_ready=0 at cnt=3, m_data held; m_ready=1 releases in order.
REQ-034 SHALL cover: AXIS_Source PROB_VALID=1, AXIS_Sink PROB_READY=10, 100 packets of 40 random beats -> every output equals packed reference, zero mismatches.
REQ-035 SHALL cover: rstn=0 after 2 of 4 beats, then 0xA1..0xA4 -> output 0xA4A3A2A1.
REQ-036 SHALL cover (LAST_EN): 0x01,0x02 with s_last on 0x02 -> m_data=0x00000201, m_keep=4'b0011, m_last=1; next beat lands in slot 0.
